sqrt_arbiter: RTL

//  Shares one integer sqrt unit among N requesters. Round-robin arbitration picks one

---
 rtl/sqrt_arbiter_if.sv | 27 ++
 rtl/sqrt_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/sqrt_arbiter_if.sv
// Request/response channel bundle between client blocks and the shared sqrt arbiter.
// master = client side, slave = arbiter side.
interface sqrt_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_rad;
  logic [N-1:0]       req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [WIDTH-1:0]   resp_root;
  logic [WIDTH-1:0]   resp_rem;

  modport master (
    output req_valid, req_rad, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_root, resp_rem
  );

  modport slave (
    input  req_valid, req_rad, resp_ready,
    output req_ready, resp_valid, resp_id, resp_root, resp_rem
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one iterative integer sqrt unit among N requesters;
// one request in flight at a time, result returned tagged with the requester index.
module sqrt_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  sqrt_arbiter_if.slave    bus,
  output logic             sq_start,
  output logic [WIDTH-1:0] sq_rad,
  input  logic             sq_busy,
  input  logic             sq_valid,
  input  logic [WIDTH-1:0] sq_root,
  input  logic [WIDTH-1:0] sq_rem
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic [IDW:0]     cand;
  logic [WIDTH-1:0] win_rad;
  logic [IDW-1:0]   resp_id_q;
  logic [WIDTH-1:0] resp_root_q;
  logic [WIDTH-1:0] resp_rem_q;

  // Search starts one past the last winner and wraps, so every requester gets a turn.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant_idx   = last_grant;
    grant_found = 1'b0;
    cand        = '0;
    for (int off = 1; off <= N; off++) begin
      cand = {1'b0, last_grant} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign win_rad = bus.req_rad[grant_idx*WIDTH +: WIDTH];

  // Ready is offered only in IDLE and never while reset is held.
  assign bus.req_ready  = (state == S_IDLE && rst_n && grant_found) ? (N'(1) << grant_idx) : '0;
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_root  = resp_root_q;
  assign bus.resp_rem   = resp_rem_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= IDW'(N - 1);
      sq_start    <= 1'b0;
      sq_rad      <= '0;
      resp_id_q   <= '0;
      resp_root_q <= '0;
      resp_rem_q  <= '0;
    end else begin
      sq_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            state      <= S_START;
            sq_start   <= 1'b1;
            sq_rad     <= win_rad;
            resp_id_q  <= grant_idx;
            last_grant <= grant_idx;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          // The sqrt unit is unreset, so its outputs are trusted only here.
          if (sq_valid && !sq_busy) begin
            resp_root_q <= sq_root;
            resp_rem_q  <= sq_rem;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
